// File: rtl/handshake_pkg.sv
// Shared definitions for the four-phase handshake sender: FSM state encoding
// and a ceiling-log2 helper for sizing counters.
package handshake_pkg;

    typedef enum logic [1:0] {
        DRAIN   = 2'd0,
        IDLE    = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/handshake_sender_if.sv
// Signal bundle between a word source, the handshake sender and the remote
// acknowledger; master is the sender side, slave is everything around it.
interface handshake_sender_if #(
    parameter int DATA_W = 8,
    parameter int DROP_W = 8
);
    logic              send;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              req;
    logic [DATA_W-1:0] data_out;
    logic              ack;
    logic              done;
    logic [DROP_W-1:0] dropped;
    logic              timeout;

    modport master (
        input  send, data_in, ack,
        output ready, req, data_out, done, dropped, timeout
    );

    modport slave (
        output send, data_in, ack,
        input  ready, req, data_out, done, dropped, timeout
    );
endinterface

// File: rtl/handshake_sender_sync.sv
// Multi-flop level synchronizer (EXTRA_DEPTH+2 stages) with edge detect outputs.
// Deliberately unreset so an input held through reset is already visible after it.
module handshake_sender_sync #(
    parameter int EXTRA_DEPTH = 1
) (
    input  logic clk,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);
    localparam int DEPTH = EXTRA_DEPTH + 2;

    logic [DEPTH-1:0] chain_reg;
    logic             last_reg;

    always_ff @(posedge clk) begin
        chain_reg[0] <= async_in;
    end

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
        always_ff @(posedge clk) begin
            chain_reg[gi] <= chain_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        last_reg <= chain_reg[DEPTH-1];
    end

    assign sync_out = chain_reg[DEPTH-1];
    assign rise     = chain_reg[DEPTH-1] & ~last_reg;
    assign fall     = ~chain_reg[DEPTH-1] & last_reg;
endmodule

// File: rtl/handshake_sender.sv
// Source side of a four-phase req/ack crossing. Optional transfer abort is
// enabled by defining HANDSHAKE_SENDER_TIMEOUT_EN.
module handshake_sender
    import handshake_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SYNC_EXTRA = 1,
    parameter int DROP_W     = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic               clk,
    input  logic               rst,
    handshake_sender_if.master bus
);
    state_t            state_reg;
    logic              req_reg;
    logic              ready_reg;
    logic              done_reg;
    logic              timeout_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DROP_W-1:0] dropped_reg;
    logic              ack_s;
    logic              ack_rise_unused;
    logic              ack_fall_unused;
    logic              expired;

    handshake_sender_sync #(
        .EXTRA_DEPTH(SYNC_EXTRA)
    ) u_ack_sync (
        .clk     (clk),
        .async_in(bus.ack),
        .sync_out(ack_s),
        .rise    (ack_rise_unused),
        .fall    (ack_fall_unused)
    );

`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Counts cycles spent in REQ/RELEASE; restarted on every entry to either state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if ((state_reg == IDLE && bus.send) || (state_reg == REQ && ack_s)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (cnt_reg == CNT_LAST);
`else
    localparam int timeout_param_unused = TIMEOUT;
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DRAIN;
            req_reg     <= 1'b0;
            ready_reg   <= 1'b0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            dropped_reg <= '0;
        end else begin
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            if (bus.send && !ready_reg && dropped_reg != {DROP_W{1'b1}}) begin
                dropped_reg <= dropped_reg + 1'b1;
            end
            case (state_reg)
                DRAIN: begin
                    if (!ack_s) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.send) begin
                        data_reg  <= bus.data_in;
                        req_reg   <= 1'b1;
                        ready_reg <= 1'b0;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (expired) begin
                        req_reg     <= 1'b0;
                        timeout_reg <= 1'b1;
                        state_reg   <= DRAIN;
                    end else if (ack_s) begin
                        req_reg   <= 1'b0;
                        state_reg <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (expired) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= DRAIN;
                    end else if (!ack_s) begin
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= DRAIN;
            endcase
        end
    end

    assign bus.req      = req_reg;
    assign bus.ready    = ready_reg;
    assign bus.data_out = data_reg;
    assign bus.done     = done_reg;
    assign bus.timeout  = timeout_reg;
    assign bus.dropped  = dropped_reg;
endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender: reset/drain, single transfer, dropped
// strobes, saturation, back-to-back sends, abort/timeout and mid-transfer reset.
module tb_handshake_sender;
    import handshake_pkg::*;

    localparam int L = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    handshake_sender_if #(.DATA_W(8), .DROP_W(8)) bus ();
    handshake_sender_if #(.DATA_W(8), .DROP_W(2)) bus2 ();

    handshake_sender #(.DATA_W(8), .SYNC_EXTRA(1), .DROP_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    handshake_sender #(.DATA_W(8), .SYNC_EXTRA(1), .DROP_W(2), .TIMEOUT(15)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_drop = 8'd0;

    task automatic tick();
        @(negedge clk);
    endtask

    // Advances one cycle while modelling the dropped counter of dut.
    task automatic tick_drop();
        if (bus.send && !bus.ready && exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
        @(negedge clk);
    endtask

    task automatic finish_xfer();
        int seen_done;
        seen_done = 0;
        bus.ack = 1'b1;
        for (int i = 0; i < 12 && bus.req; i++) tick_drop();
        checks++;
        if (bus.req !== 1'b0) begin errors++; $display("FAIL fin_req_fall got %0b exp 0", bus.req); end
        bus.ack = 1'b0;
        for (int i = 0; i < 12 && !bus.ready; i++) begin
            tick_drop();
            if (bus.done) seen_done++;
        end
        checks++;
        if (bus.ready !== 1'b1 || seen_done != 1) begin
            errors++; $display("FAIL fin_ready got ready=%0b done_pulses=%0d exp ready=1 done_pulses=1", bus.ready, seen_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.send = 1'b0; bus.data_in = 8'h00; bus.ack = 1'b1;
        bus2.send = 1'b0; bus2.data_in = 8'h00; bus2.ack = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({bus.req, bus.ready, bus.done, bus.timeout} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {bus.req, bus.ready, bus.done, bus.timeout});
        end
        checks++;
        if (bus.data_out !== 8'h00 || bus.dropped !== 8'h00) begin
            errors++; $display("FAIL reset_regs got data_out=%h dropped=%h exp 00 00", bus.data_out, bus.dropped);
        end
        checks++;
        if (dut.state_reg !== DRAIN) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_reg, DRAIN); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.ready !== 1'b0 || bus.req !== 1'b0) begin
                errors++; $display("FAIL drain_hold cyc %0d got ready=%0b req=%0b exp 0 0", i, bus.ready, bus.req);
            end
        end
        bus.ack = 1'b0; bus2.ack = 1'b0;
        for (int i = 0; i < L; i++) begin
            tick();
            checks++;
            if (bus.ready !== 1'b0) begin errors++; $display("FAIL drain_lat cyc %0d got ready=%0b exp 0", i, bus.ready); end
        end
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus2.ready !== 1'b1) begin
            errors++; $display("FAIL drain_exit got ready=%0b ready2=%0b exp 1 1", bus.ready, bus2.ready);
        end
        $display("reset/drain sequence complete");
    endtask

    task automatic test_transfer();
        bus.data_in = 8'hA5; bus.send = 1'b1;
        tick();
        bus.send = 1'b0; bus.data_in = 8'h00;
        checks++;
        if (bus.req !== 1'b1 || bus.ready !== 1'b0 || bus.data_out !== 8'hA5) begin
            errors++; $display("FAIL xfer_accept got req=%0b ready=%0b data=%h exp 1 0 a5", bus.req, bus.ready, bus.data_out);
        end
        tick();
        bus.ack = 1'b1;
        for (int i = 0; i < L; i++) begin
            tick();
            checks++;
            if (bus.req !== 1'b1 || bus.data_out !== 8'hA5 || bus.done !== 1'b0) begin
                errors++; $display("FAIL xfer_wait_ack cyc %0d got req=%0b data=%h done=%0b exp 1 a5 0", i, bus.req, bus.data_out, bus.done);
            end
        end
        tick();
        checks++;
        if (bus.req !== 1'b0) begin errors++; $display("FAIL xfer_req_fall got %0b exp 0", bus.req); end
        tick();
        bus.ack = 1'b0;
        for (int i = 0; i < L; i++) begin
            tick();
            checks++;
            if (bus.ready !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 8'hA5) begin
                errors++; $display("FAIL xfer_release cyc %0d got ready=%0b done=%0b data=%h exp 0 0 a5", i, bus.ready, bus.done, bus.data_out);
            end
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.data_out !== 8'hA5) begin
            errors++; $display("FAIL xfer_done got done=%0b ready=%0b data=%h exp 1 1 a5", bus.done, bus.ready, bus.data_out);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            errors++; $display("FAIL xfer_done_pulse got done=%0b ready=%0b exp 0 1", bus.done, bus.ready);
        end
        $display("transfer data=a5 complete");
    endtask

    task automatic test_drop();
        bus.data_in = 8'h3C; bus.send = 1'b1;
        tick_drop();
        bus.send = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.data_in = 8'h10 + 8'(i); bus.send = 1'b1;
            tick_drop();
            bus.send = 1'b0;
            tick_drop();
        end
        checks++;
        if (bus.dropped !== 8'd3 || bus.dropped !== exp_drop) begin
            errors++; $display("FAIL drop_count got %0d exp 3", bus.dropped);
        end
        checks++;
        if (bus.data_out !== 8'h3C || bus.req !== 1'b1) begin
            errors++; $display("FAIL drop_data got data=%h req=%0b exp 3c 1", bus.data_out, bus.req);
        end
        finish_xfer();
        checks++;
        if (bus.dropped !== 8'd3) begin errors++; $display("FAIL drop_after got %0d exp 3", bus.dropped); end
        $display("transfer data=3c with 3 dropped strobes complete");
    endtask

    task automatic test_saturate();
        logic [1:0] exp2;
        bus2.data_in = 8'h77; bus2.send = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp2 = (i >= 3) ? 2'd3 : 2'(i);
            checks++;
            if (bus2.dropped !== exp2) begin errors++; $display("FAIL sat_count strobe %0d got %0d exp %0d", i, bus2.dropped, exp2); end
        end
        bus2.send = 1'b0;
        checks++;
        if (bus2.data_out !== 8'h77) begin errors++; $display("FAIL sat_data got %h exp 77", bus2.data_out); end
        $display("saturation run of 10 strobes complete");
    endtask

    task automatic test_back_to_back();
        bus.data_in = 8'h5A; bus.send = 1'b1;
        tick_drop();
        checks++;
        if (bus.req !== 1'b1 || bus.data_out !== 8'h5A) begin
            errors++; $display("FAIL b2b_first got req=%0b data=%h exp 1 5a", bus.req, bus.data_out);
        end
        bus.ack = 1'b1;
        for (int i = 0; i < 12 && bus.req; i++) tick_drop();
        bus.ack = 1'b0;
        for (int i = 0; i < 12 && !bus.ready; i++) tick_drop();
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b1) begin
            errors++; $display("FAIL b2b_done_ready got ready=%0b done=%0b exp 1 1", bus.ready, bus.done);
        end
        bus.data_in = 8'h5B;
        tick_drop();
        bus.send = 1'b0;
        checks++;
        if (bus.data_out !== 8'h5B || bus.req !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL b2b_second got data=%h req=%0b done=%0b exp 5b 1 0", bus.data_out, bus.req, bus.done);
        end
        checks++;
        if (bus.dropped !== exp_drop) begin errors++; $display("FAIL b2b_dropped got %0d exp %0d", bus.dropped, exp_drop); end
        finish_xfer();
        $display("back-to-back transfers 5a,5b complete dropped=%0d", exp_drop);
    endtask

    task automatic test_timeout();
        bus.data_in = 8'hC3; bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 1; i < 15; i++) begin
                tick();
                checks++;
                if (bus.timeout !== 1'b0 || bus.req !== 1'b1) begin
                    errors++; $display("FAIL to_early cyc %0d got timeout=%0b req=%0b exp 0 1", i, bus.timeout, bus.req);
                end
            end
            tick();
            checks++;
            if (bus.timeout !== 1'b1 || bus.req !== 1'b0) begin
                errors++; $display("FAIL to_pulse got timeout=%0b req=%0b exp 1 0", bus.timeout, bus.req);
            end
            for (int i = 0; i < L + 1 && !bus.ready; i++) begin
                tick();
                if (bus.done) seen_done++;
            end
            checks++;
            if (bus.ready !== 1'b1 || seen_done != 0 || bus.timeout !== 1'b0) begin
                errors++; $display("FAIL to_recover got ready=%0b done_pulses=%0d timeout=%0b exp 1 0 0", bus.ready, seen_done, bus.timeout);
            end
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.timeout !== 1'b0 || bus.req !== 1'b1) begin
                errors++; $display("FAIL to_disabled cyc %0d got timeout=%0b req=%0b exp 0 1", i, bus.timeout, bus.req);
            end
        end
        finish_xfer();
`endif
        $display("stalled transfer data=c3 handled");
    endtask

    task automatic test_reset_in_req();
        bus.data_in = 8'h99; bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        checks++;
        if (dut.state_reg !== REQ || bus.req !== 1'b1) begin
            errors++; $display("FAIL rreq_setup got state=%0d req=%0b exp %0d 1", dut.state_reg, bus.req, REQ);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.req !== 1'b0 || bus.done !== 1'b0 || dut.state_reg !== DRAIN) begin
            errors++; $display("FAIL rreq_abort got req=%0b done=%0b state=%0d exp 0 0 %0d", bus.req, bus.done, dut.state_reg, DRAIN);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.dropped !== 8'd0) begin
            errors++; $display("FAIL rreq_recover got ready=%0b done=%0b dropped=%0d exp 1 0 0", bus.ready, bus.done, bus.dropped);
        end
        $display("reset during REQ handled");
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_drop();
        test_saturate();
        test_back_to_back();
        test_timeout();
        test_reset_in_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
